// File: rtl/hs_pkg.sv
// Shared handshake definitions: burst-source FSM encodings and LFSR constants,
// also used by downstream checker blocks.
package hs_pkg;

   typedef enum logic [1:0] {
      HS_IDLE = 2'd0,
      HS_SEND = 2'd1,
      HS_DONE = 2'd2
   } hs_state_e;

   localparam logic [7:0] HS_LFSR_SEED = 8'hA5;
   // Taps 8,6,5,4 of the Fibonacci LFSR, as a bit mask over state[7:0].
   localparam logic [7:0] HS_LFSR_TAPS = 8'hB8;

   function automatic logic [7:0] hs_lfsr8_next(input logic [7:0] s);
      return {s[6:0], ^(s & HS_LFSR_TAPS)};
   endfunction

endpackage

// File: rtl/hs_lfsr8.sv
// 8-bit Fibonacci LFSR with synchronous seed load; steps once per enabled cycle.
module hs_lfsr8
   import hs_pkg::*;
(
   input  logic       clk,
   input  logic       s_rst_n,
   input  logic       en,
   input  logic       load,
   output logic [7:0] state
);

   logic [7:0] state_q;

   always_ff @(posedge clk or negedge s_rst_n) begin
      if (!s_rst_n) begin
         state_q <= HS_LFSR_SEED;
      end else if (load) begin
         state_q <= HS_LFSR_SEED;
      end else if (en) begin
         state_q <= hs_lfsr8_next(state_q);
      end
   end

   assign state = state_q;

endmodule

// File: rtl/hs_burst_source.sv
// Valid/ready burst source: emits DEPTH incrementing words from INIT_VAL per start.
// Optional random valid gaps between words when HS_SRC_THROTTLE_EN is defined.
module hs_burst_source
   import hs_pkg::*;
#(
   parameter int unsigned WIDTH    = 8,
   parameter int unsigned DEPTH    = 256,
   parameter int unsigned INIT_VAL = 0
) (
   input  logic             clk,
   input  logic             s_rst_n,
   input  logic             start,
   input  logic             src_ready,
   output logic             src_vaild,
   output logic [WIDTH-1:0] src_data_out,
   output logic             busy,
   output logic             done
);

   localparam int unsigned      CNT_W = $clog2(DEPTH) + 1;
   localparam logic [CNT_W-1:0] LAST  = CNT_W'(DEPTH - 1);
   localparam logic [WIDTH-1:0] INIT  = WIDTH'(INIT_VAL);

   hs_state_e        state_q, state_d;
   logic             valid_q, valid_d;
   logic [WIDTH-1:0] data_q, data_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             gap_q, gap_d;
   logic             hs;
   logic             accept;
   logic             throttle;

   assign hs     = valid_q & src_ready;
   assign accept = (state_q == HS_IDLE) & start;

`ifdef HS_SRC_THROTTLE_EN
   logic [7:0] lfsr_state;

   hs_lfsr8 u_lfsr (
      .clk     (clk),
      .s_rst_n (s_rst_n),
      .en      (hs),
      .load    (accept),
      .state   (lfsr_state)
   );

   // The feedback bit is bit0 of the LFSR value produced by this handshake's step.
   assign throttle = ^(lfsr_state & HS_LFSR_TAPS);
`else
   assign throttle = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      valid_d = valid_q;
      data_d  = data_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      cnt_d   = cnt_q;
      gap_d   = 1'b0;
      unique case (state_q)
         HS_IDLE: begin
            if (start) begin
               state_d = HS_SEND;
               valid_d = 1'b1;
               data_d  = INIT;
               busy_d  = 1'b1;
               cnt_d   = '0;
            end
         end
         HS_SEND: begin
            if (gap_q) begin
               valid_d = 1'b1;
            end else if (hs) begin
               if (cnt_q == LAST) begin
                  state_d = HS_DONE;
                  valid_d = 1'b0;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
               end else begin
                  cnt_d   = cnt_q + CNT_W'(1);
                  data_d  = data_q + WIDTH'(1);
                  gap_d   = throttle;
                  valid_d = ~throttle;
               end
            end
         end
         HS_DONE: state_d = HS_IDLE;
         default: state_d = HS_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge s_rst_n) begin
      if (!s_rst_n) begin
         state_q <= HS_IDLE;
         valid_q <= 1'b0;
         data_q  <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         cnt_q   <= '0;
         gap_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         valid_q <= valid_d;
         data_q  <= data_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         cnt_q   <= cnt_d;
         gap_q   <= gap_d;
      end
   end

   assign src_vaild    = valid_q;
   assign src_data_out = data_q;
   assign busy         = busy_q;
   assign done         = done_q;

endmodule

// File: tb/tb_hs_burst_source.sv
// Bench for hs_burst_source: vector tables, directed corner sequences and a random
// run of a DEPTH=16 instance against a behavioural model.
module tb_hs_burst_source;

`ifdef HS_SRC_THROTTLE_EN
   localparam bit Thr = 1'b1;
`else
   localparam bit Thr = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic       start_a = 0, ready_a = 0, valid_a, busy_a, done_a;
   logic       start_b = 0, ready_b = 0, valid_b, busy_b, done_b;
   logic       start_c = 0, ready_c = 0, valid_c, busy_c, done_c;
   logic       start_d = 0, ready_d = 0, valid_d, busy_d, done_d;
   logic [7:0] data_a, data_b, data_c, data_d;

   hs_burst_source #(.WIDTH(8), .DEPTH(4), .INIT_VAL(8'hFE)) u_a (
      .clk(clk), .s_rst_n(rst_n), .start(start_a), .src_ready(ready_a),
      .src_vaild(valid_a), .src_data_out(data_a), .busy(busy_a), .done(done_a));
   hs_burst_source #(.WIDTH(8), .DEPTH(3), .INIT_VAL(0)) u_b (
      .clk(clk), .s_rst_n(rst_n), .start(start_b), .src_ready(ready_b),
      .src_vaild(valid_b), .src_data_out(data_b), .busy(busy_b), .done(done_b));
   hs_burst_source #(.WIDTH(8), .DEPTH(1), .INIT_VAL(8'h5A)) u_c (
      .clk(clk), .s_rst_n(rst_n), .start(start_c), .src_ready(ready_c),
      .src_vaild(valid_c), .src_data_out(data_c), .busy(busy_c), .done(done_c));
   hs_burst_source #(.WIDTH(8), .DEPTH(16), .INIT_VAL(0)) u_d (
      .clk(clk), .s_rst_n(rst_n), .start(start_d), .src_ready(ready_d),
      .src_vaild(valid_d), .src_data_out(data_d), .busy(busy_d), .done(done_d));

   int n_pass = 0;
   int n_total = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h at t=%0t", name, act, exp, $time);
   endtask

   // LFSR with taps 8,6,5,4 written out bit by bit; returns the new bit0.
   function automatic logic lfsr_fb(input logic [7:0] s);
      return s[7] ^ s[5] ^ s[4] ^ s[3];
   endfunction

   function automatic logic [7:0] lfsr_step(input logic [7:0] s);
      return {s[6:0], lfsr_fb(s)};
   endfunction

   // Handshake and done-pulse counters for the table-driven units.
   int hs_a = 0, hs_b = 0, dn_a = 0;
   always @(posedge clk) begin
      if (rst_n) begin
         hs_a <= hs_a + int'(valid_a & ready_a);
         hs_b <= hs_b + int'(valid_b & ready_b);
         dn_a <= dn_a + int'(done_a);
      end
   end

   // Model of u_d: words left in the burst, pending gap, done pulse, last word.
   int         m_left;
   logic       m_gap, m_done;
   logic [7:0] m_data, m_lfsr;
   bit         mdl_en = 1'b0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_left <= 0;
         m_gap  <= 1'b0;
         m_done <= 1'b0;
         m_data <= 8'h00;
         m_lfsr <= 8'hA5;
      end else if (m_left > 0) begin
         m_done <= 1'b0;
         if (m_gap) begin
            m_gap <= 1'b0;
         end else if (ready_d) begin
            m_lfsr <= lfsr_step(m_lfsr);
            m_left <= m_left - 1;
            if (m_left == 1) begin
               m_done <= 1'b1;
            end else begin
               m_data <= m_data + 8'd1;
               m_gap  <= Thr && lfsr_fb(m_lfsr);
            end
         end
      end else if (m_done) begin
         m_done <= 1'b0;
      end else if (start_d) begin
         m_left <= 16;
         m_data <= 8'h00;
         m_lfsr <= 8'hA5;
      end
   end

   always @(negedge clk) begin
      if (mdl_en && rst_n) begin
         chk("mdl_valid", 32'(valid_d), 32'(m_left > 0 && !m_gap));
         chk("mdl_data",  32'(data_d),  32'(m_data));
         chk("mdl_busy",  32'(busy_d),  32'(m_left > 0));
         chk("mdl_done",  32'(done_d),  32'(m_done));
      end
   end

   typedef struct packed {
      logic       unit;
      logic       start;
      logic       ready;
      logic       valid;
      logic [7:0] data;
      logic       busy;
      logic       done;
   } row_t;

   function automatic row_t r(logic u, logic st, logic rd, logic v, logic [7:0] d, logic b,
                              logic dn);
      row_t x;
      x = '{unit: u, start: st, ready: rd, valid: v, data: d, busy: b, done: dn};
      return x;
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      row_t       rows[$];
      logic [7:0] s;
      int         n, gaps, nrec, exp_gaps;
      logic       pend;
      logic [7:0] rec[64];

      repeat (3) @(negedge clk);
      chk("rst_a", 32'({valid_a, busy_a, done_a, data_a}), 32'd0);
      chk("rst_b", 32'({valid_b, busy_b, done_b, data_b}), 32'd0);
      chk("rst_c", 32'({valid_c, busy_c, done_c, data_c}), 32'd0);
      chk("rst_d", 32'({valid_d, busy_d, done_d, data_d}), 32'd0);
      rst_n  = 1'b1;
      mdl_en = 1'b1;
      @(negedge clk);

`ifndef HS_SRC_THROTTLE_EN
      // Free flow on u_a with start pulses in SEND and DONE, then backpressure on u_b.
      rows.push_back(r(0, 1, 1, 1, 8'hFE, 1, 0));
      rows.push_back(r(0, 0, 1, 1, 8'hFF, 1, 0));
      rows.push_back(r(0, 1, 1, 1, 8'h00, 1, 0));
      rows.push_back(r(0, 0, 1, 1, 8'h01, 1, 0));
      rows.push_back(r(0, 0, 1, 0, 8'h01, 0, 1));
      rows.push_back(r(0, 1, 1, 0, 8'h01, 0, 0));
      rows.push_back(r(0, 0, 1, 0, 8'h01, 0, 0));
      rows.push_back(r(0, 0, 1, 0, 8'h01, 0, 0));
      rows.push_back(r(1, 1, 0, 1, 8'h00, 1, 0));
      for (int i = 0; i < 5; i++) rows.push_back(r(1, 0, 0, 1, 8'h00, 1, 0));
      rows.push_back(r(1, 0, 1, 1, 8'h01, 1, 0));
      rows.push_back(r(1, 0, 1, 1, 8'h02, 1, 0));
      rows.push_back(r(1, 0, 1, 0, 8'h02, 0, 1));
      rows.push_back(r(1, 0, 1, 0, 8'h02, 0, 0));
      foreach (rows[i]) begin
         logic [10:0] got;
         start_a = 0; ready_a = 0; start_b = 0; ready_b = 0;
         if (rows[i].unit == 1'b0) begin
            start_a = rows[i].start; ready_a = rows[i].ready;
         end else begin
            start_b = rows[i].start; ready_b = rows[i].ready;
         end
         @(posedge clk);
         @(negedge clk);
         got = (rows[i].unit == 1'b0) ? {valid_a, data_a, busy_a, done_a}
                                      : {valid_b, data_b, busy_b, done_b};
         chk($sformatf("vec%0d", i), 32'(got),
             32'({rows[i].valid, rows[i].data, rows[i].busy, rows[i].done}));
      end
      start_a = 0; ready_a = 0; start_b = 0; ready_b = 0;
      chk("hs_count_a", 32'(hs_a), 32'd4);
      chk("done_count_a", 32'(dn_a), 32'd1);
      chk("hs_count_b", 32'(hs_b), 32'd3);
`endif

      // DEPTH=1 with start held: valid every third cycle, done the cycle after.
      start_c = 1; ready_c = 1;
      for (int k = 0; k < 9; k++) begin
         @(posedge clk);
         @(negedge clk);
         chk($sformatf("d1_valid%0d", k), 32'(valid_c), 32'(k % 3 == 0));
         chk($sformatf("d1_done%0d", k), 32'(done_c), 32'(k % 3 == 1));
         chk($sformatf("d1_data%0d", k), 32'(data_c), 32'h5A);
      end
      start_c = 0; ready_c = 0;

      // Reset mid-burst on u_d after three handshakes.
      start_d = 1; ready_d = 1;
      @(posedge clk);
      @(negedge clk);
      start_d = 0;
      n = 0;
      for (int k = 0; k < 50 && n < 3; k++) begin
         pend = valid_d & ready_d;
         @(posedge clk);
         if (pend) n++;
         @(negedge clk);
      end
      chk("pre_rst_hs", 32'(n), 32'd3);
      chk("pre_rst_data", 32'(data_d), 32'd3);
      mdl_en = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      chk("async_rst", 32'({valid_d, busy_d, done_d, data_d}), 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst_n  = 1'b1;
      mdl_en = 1'b1;
      @(negedge clk);
      chk("idle_after_rst", 32'({valid_d, busy_d}), 32'd0);
      start_d = 1;
      @(posedge clk);
      @(negedge clk);
      start_d = 0;
      chk("restart_data0", 32'({valid_d, data_d}), 32'h100);
      @(posedge clk);
      @(negedge clk);
      chk("restart_data1", 32'(data_d), 32'd1);
      for (int k = 0; k < 100 && !done_d; k++) @(negedge clk);
      chk("restart_done", 32'(done_d), 32'd1);
      @(negedge clk);

      // Full burst on u_d with ready high: data intact, gaps match the LFSR.
      s = 8'hA5;
      exp_gaps = 0;
      for (int i = 0; i < 15; i++) begin
         s = lfsr_step(s);
         exp_gaps += (Thr && s[0]) ? 1 : 0;
      end
      start_d = 1; ready_d = 1;
      @(posedge clk);
      @(negedge clk);
      start_d = 0;
      gaps = 0;
      nrec = 0;
      for (int k = 0; k < 100 && !done_d; k++) begin
         if (busy_d && !valid_d) gaps++;
         if (valid_d && ready_d && nrec < 64) begin
            rec[nrec] = data_d;
            nrec++;
         end
         @(posedge clk);
         @(negedge clk);
      end
      chk("burst_done", 32'(done_d), 32'd1);
      chk("burst_words", 32'(nrec), 32'd16);
      chk("burst_gaps", 32'(gaps), 32'(exp_gaps));
      for (int i = 0; i < nrec && i < 16; i++) chk($sformatf("burst_data%0d", i), 32'(rec[i]),
                                                    32'(i));
      @(negedge clk);

      // Random start/ready on u_d, checked cycle by cycle against the model.
      for (int k = 0; k < 1500; k++) begin
         start_d = ($urandom_range(3) == 0);
         ready_d = ($urandom_range(3) != 0);
         @(negedge clk);
      end
      start_d = 0; ready_d = 0;
      @(negedge clk);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
